// File: rtl/iob_rom_stream_reader.sv
// Burst reader for a 1-cycle-latency synchronous ROM port: turns (base, length)
// requests into a valid/ready stream through a 4-entry skid FIFO.
module iob_rom_stream_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rom_r_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_r_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ZERO = {(ADDR_W+1){1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   out_cnt;
    logic              rd_pend;
    logic [DATA_W-1:0] fifo_mem [0:3];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        fifo_count;
    logic              push;
    logic              pop;
    logic              can_issue;

    // Words already buffered plus the one on the ROM bus bound new issues, so
    // at most four words are ever in flight and the FIFO cannot overflow.
    assign push      = rd_pend;
    assign pop       = valid_o && ready_i;
    assign can_issue = (issue_cnt != LEN_ZERO) && ((fifo_count + {2'b00, rd_pend}) <= 3'd2);
    assign valid_o   = (fifo_count != 3'd0);
    assign data_o    = fifo_mem[rd_ptr];
    assign last_o    = valid_o && (out_cnt == LEN_ONE);

    // Capture FIFO: push ROM data one cycle after each read, pop on handshake
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= {DATA_W{1'b0}};
            end
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rom_r_data_i;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Control FSM with registered ROM port and status outputs
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            rom_r_en_o <= 1'b0;
            rom_addr_o <= {ADDR_W{1'b0}};
            next_addr  <= {ADDR_W{1'b0}};
            issue_cnt  <= LEN_ZERO;
            out_cnt    <= LEN_ZERO;
            rd_pend    <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            rd_pend <= rom_r_en_o;
            if (pop) begin
                out_cnt <= out_cnt - LEN_ONE;
            end
            case (state)
                IDLE: begin
                    rom_r_en_o <= 1'b0;
                    if (start_i) begin
                        if (len_i != LEN_ZERO) begin
                            // First read goes out on the accepting edge itself
                            state      <= RUN;
                            busy_o     <= 1'b1;
                            rom_r_en_o <= 1'b1;
                            rom_addr_o <= base_addr_i;
                            next_addr  <= base_addr_i + ADDR_ONE;
                            issue_cnt  <= len_i - LEN_ONE;
                            out_cnt    <= len_i;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (can_issue) begin
                        rom_r_en_o <= 1'b1;
                        rom_addr_o <= next_addr;
                        next_addr  <= next_addr + ADDR_ONE;
                        issue_cnt  <= issue_cnt - LEN_ONE;
                    end else begin
                        rom_r_en_o <= 1'b0;
                    end
                    if (issue_cnt == LEN_ZERO) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    rom_r_en_o <= 1'b0;
                    if (pop && (out_cnt == LEN_ONE)) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy_o     <= 1'b0;
                    rom_r_en_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_rom_stream_reader.sv
// Self-checking bench for iob_rom_stream_reader: directed scenarios plus random
// bursts, checked against a queue-based model of the expected word stream.
module tb_iob_rom_stream_reader;

    logic       clk = 1'b0;
    logic       arst;
    logic       start;
    logic [3:0] base;
    logic [4:0] len;
    logic       busy;
    logic       done;
    logic       rom_r_en;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       last;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         hs_cycles[$];
    logic       busy_exp = 1'b0;
    logic       done_exp = 1'b0;
    logic       hold_valid = 1'b0;
    logic [3:0] exp_addr = 4'd0;
    int         exp_len = 0;
    int         issued = 0;
    int         popped = 0;
    int         stall_cnt = 0;
    logic [7:0] last_hs_data = 8'd0;

    always #5 clk = ~clk;

    // ROM contents: rom[i] = i + 32, one cycle read latency
    always @(posedge clk) begin
        if (rom_r_en) rom_data <= 8'd32 + {4'd0, rom_addr};
    end

    iob_rom_stream_reader #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk_i(clk), .arst_i(arst), .start_i(start), .base_addr_i(base),
        .len_i(len), .busy_o(busy), .done_o(done), .rom_r_en_o(rom_r_en),
        .rom_addr_o(rom_addr), .rom_r_data_i(rom_data), .data_o(data),
        .valid_o(valid), .ready_i(ready), .last_o(last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, update the model, return just after posedge
    task automatic tick();
        logic hs;
        logic done_nxt;
        logic busy_nxt;
        @(negedge clk);
        chk("done", done, done_exp);
        chk("busy", busy, busy_exp);
        if (hold_valid) chk("valid_hold", valid, 1'b1);
        if (!busy_exp) chk("ren_idle", rom_r_en, 1'b0);
        if (rom_r_en && busy_exp) begin
            chk("ren_extra", issued < exp_len, 32'd1);
            chk("addr", rom_addr, exp_addr);
            exp_addr = exp_addr + 4'd1;
            issued++;
            chk("inflight", (issued - popped) <= 4, 32'd1);
        end
        if (busy_exp && issued > 0 && issued < exp_len && !rom_r_en) stall_cnt++;
        if (valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", valid, 1'b0);
            end else begin
                chk("data", data, exp_q[0]);
                chk("last", last, exp_q.size() == 1);
            end
        end else begin
            chk("last_idle", last, 1'b0);
        end
        hs = valid && ready;
        done_nxt = 1'b0;
        busy_nxt = busy_exp;
        if (hs && exp_q.size() > 0) begin
            last_hs_data = exp_q.pop_front();
            hs_cycles.push_back(cyc);
            popped++;
            if (exp_q.size() == 0) begin
                busy_nxt = 1'b0;
                done_nxt = 1'b1;
                chk("issued_total", issued, exp_len);
            end
        end
        if (start && !busy_exp) begin
            if (len != 5'd0) begin
                for (int i = 0; i < int'(len); i++) exp_q.push_back(8'(((int'(base) + i) % 16) + 32));
                exp_len  = int'(len);
                exp_addr = base;
                issued   = 0;
                popped   = 0;
                busy_nxt = 1'b1;
            end else begin
                done_nxt = 1'b1;
            end
        end
        hold_valid = valid && !ready;
        done_exp   = done_nxt;
        busy_exp   = busy_nxt;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch(input logic [3:0] b, input logic [4:0] l);
        base  = b;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: ready held high, 1: 1,0,0,1,0,1 pattern, 2: random ready + stray starts
    task automatic run_until_idle(input int mode);
        int n;
        logic [5:0] pat;
        pat = 6'b101001;
        n = 0;
        while (busy_exp && n < 300) begin
            case (mode)
                1:       ready = pat[n % 6];
                2: begin
                    ready = ($urandom_range(0, 9) < 7);
                    start = ($urandom_range(0, 7) == 0);
                    base  = 4'($urandom);
                    len   = 5'($urandom_range(0, 16));
                end
                default: ready = 1'b1;
            endcase
            tick();
            start = 1'b0;
            n++;
        end
        chk("timeout", busy_exp, 1'b0);
        tick();
    endtask

    initial begin
        arst  = 1'b1;
        start = 1'b0;
        base  = 4'd0;
        len   = 5'd0;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ren", rom_r_en, 1'b0);
        chk("rst_addr", rom_addr, 4'd0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_data", data, 8'd0);
        arst = 1'b0;
        tick();

        // 1: full-depth burst at full rate, latency 3 and no bubbles
        ready = 1'b1;
        hs_cycles.delete();
        begin
            int s;
            s = cyc;
            launch(4'd0, 5'd16);
            run_until_idle(0);
            chk("t1_count", hs_cycles.size(), 32'd16);
            if (hs_cycles.size() == 16) begin
                chk("t1_first_lat", hs_cycles[0] - s, 32'd3);
                chk("t1_last_lat", hs_cycles[15] - s, 32'd18);
            end
        end
        chk("t1_last_word", last_hs_data, 8'd47);

        // 2: address wrap
        launch(4'd14, 5'd4);
        run_until_idle(0);
        chk("t2_last_word", last_hs_data, 8'd33);

        // 3: toggling backpressure forces read stalls
        stall_cnt = 0;
        ready = 1'b1;
        launch(4'd3, 5'd6);
        run_until_idle(1);
        chk("t3_last_word", last_hs_data, 8'd40);
        chk("t3_stalled", stall_cnt > 0, 32'd1);

        // 4: zero-length request
        ready = 1'b1;
        launch(4'd7, 5'd0);
        tick();
        tick();

        // 5: start while busy is ignored
        launch(4'd1, 5'd8);
        tick();
        base  = 4'd8;
        len   = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_idle(0);
        chk("t5_last_word", last_hs_data, 8'd40);

        // 6: asynchronous reset mid-burst, then a fresh burst
        launch(4'd0, 5'd10);
        begin
            int n;
            n = 0;
            while (popped < 3 && n < 50) begin
                tick();
                n++;
            end
        end
        chk("t6_popped", popped, 32'd3);
        arst = 1'b1;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_ren", rom_r_en, 1'b0);
        chk("t6_addr", rom_addr, 4'd0);
        chk("t6_valid", valid, 1'b0);
        chk("t6_last", last, 1'b0);
        chk("t6_data", data, 8'd0);
        exp_q.delete();
        busy_exp   = 1'b0;
        done_exp   = 1'b0;
        hold_valid = 1'b0;
        tick();
        arst = 1'b0;
        tick();
        launch(4'd5, 5'd2);
        run_until_idle(0);
        chk("t6_new_last", last_hs_data, 8'd38);

        // Random bursts with random backpressure and stray starts
        for (int k = 0; k < 40; k++) begin
            ready = ($urandom_range(0, 1) == 1);
            launch(4'($urandom), 5'($urandom_range(0, 16)));
            run_until_idle(2);
        end
        chk("rand_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
